// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared line geometry, state encoding and bus constants for the cache master
package cache_pkg;
    localparam int         LINE_WORDS_DEF = 16;
    localparam int         BYTE_OFF_W     = 2;
    localparam logic [3:0] BE_ALL         = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WB_FETCH,
        WB_WRITE,
        DONE
    } state_t;

    function automatic int word_off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int line_addr_w(input int line_words);
        return 32 - $clog2(line_words) - BYTE_OFF_W;
    endfunction
endpackage

// File: rtl/cache_rw_master_wbuf.sv
// rtl/cache_rw_master_wbuf.sv - one-entry writeback holding register behind the 1-cycle data RAM
module cache_rw_master_wbuf (
    input  logic        clk,
    input  logic        rest,
    input  logic        i_ram_rd,
    input  logic [31:0] i_ram_data,
    output logic [31:0] o_data
);
    logic        r_fresh;
    logic [31:0] r_hold;

    // RAM output is only trustworthy the cycle after a read; later cycles replay the captured copy
    always_ff @(posedge clk) begin
        if (rest) begin
            r_fresh <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_fresh <= i_ram_rd;
            if (r_fresh) r_hold <= i_ram_data;
        end
    end

    assign o_data = r_fresh ? i_ram_data : r_hold;
endmodule

// File: rtl/cache_rw_master.sv
// rtl/cache_rw_master.sv - line fill / writeback initiator on m0; CACHE_RW_MASTER_CWF_EN enables critical word first
module cache_rw_master
    import cache_pkg::*;
#(
    parameter int LINE_WORDS  = LINE_WORDS_DEF,
    parameter int MAX_PENDING = 4
) (
    input  logic                                 clk,
    input  logic                                 rest,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic                                 cmd_write,
    input  logic [line_addr_w(LINE_WORDS)-1:0]   cmd_lineAddr,
    input  logic [word_off_w(LINE_WORDS)-1:0]    cmd_wordOffset,
    output logic                                 fill_valid,
    output logic [word_off_w(LINE_WORDS)-1:0]    fill_index,
    output logic [31:0]                          fill_data,
    output logic                                 wb_read,
    output logic [word_off_w(LINE_WORDS)-1:0]    wb_index,
    input  logic [31:0]                          wb_data,
    output logic                                 done,
    output logic [31:0]                          m0_address,
    output logic [3:0]                           m0_byteEnable,
    output logic                                 m0_read,
    output logic                                 m0_write,
    output logic [31:0]                          m0_writeData,
    input  logic [31:0]                          m0_readData,
    input  logic                                 m0_waitRequest,
    input  logic                                 m0_readDataValid
);
    localparam int            WW    = word_off_w(LINE_WORDS);
    localparam int            AW    = line_addr_w(LINE_WORDS);
    localparam int            CW    = WW + 1;
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [WW-1:0] ONE_W = WW'(1);
    localparam logic [CW-1:0] LAST  = CW'(LINE_WORDS - 1);
    localparam logic [CW-1:0] FULL  = CW'(LINE_WORDS);
    localparam logic [CW-1:0] MAXP  = CW'(MAX_PENDING);

    state_t        r_state;
    logic [AW-1:0] r_line;
    logic [WW-1:0] r_start;
    logic [CW-1:0] r_issued;
    logic [CW-1:0] r_returned;
    logic [CW-1:0] r_pending;

    logic          w_issue;
    logic          w_return;
    logic          w_wb_adv;
    logic          w_last_wr;
    logic [WW-1:0] w_cur_word;
    logic [WW-1:0] w_ret_word;
    logic [31:0]   w_buf_data;

    // r_issued doubles as the write counter during writeback
    assign w_cur_word = r_start + r_issued[WW-1:0];
    assign w_ret_word = r_start + r_returned[WW-1:0];

    assign m0_read   = (r_state == FILL) && (r_issued < FULL) && (r_pending < MAXP);
    assign w_issue   = m0_read && !m0_waitRequest;
    assign w_return  = (r_state == FILL) && m0_readDataValid;
    assign m0_write  = (r_state == WB_WRITE);
    assign w_wb_adv  = m0_write && !m0_waitRequest;
    assign w_last_wr = (r_issued == LAST);

    // Prefetch the next RAM word in the same cycle the current write is accepted
    assign wb_read  = (r_state == WB_FETCH) || (w_wb_adv && !w_last_wr);
    assign wb_index = (r_state == WB_WRITE) ? w_cur_word + ONE_W : w_cur_word;

    assign m0_address    = (m0_read || m0_write) ? {r_line, w_cur_word, 2'b00} : '0;
    assign m0_byteEnable = BE_ALL;
    assign m0_writeData  = m0_write ? w_buf_data : '0;

    assign fill_valid = w_return;
    assign fill_index = w_return ? w_ret_word : '0;
    assign fill_data  = w_return ? m0_readData : '0;
    assign cmd_ready  = (r_state == IDLE);
    assign done       = (r_state == DONE);

    cache_rw_master_wbuf u_wbuf (
        .clk        (clk),
        .rest       (rest),
        .i_ram_rd   (wb_read),
        .i_ram_data (wb_data),
        .o_data     (w_buf_data)
    );

    always_ff @(posedge clk) begin
        if (rest) begin
            r_state    <= IDLE;
            r_line     <= '0;
            r_start    <= '0;
            r_issued   <= '0;
            r_returned <= '0;
            r_pending  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_line     <= cmd_lineAddr;
`ifdef CACHE_RW_MASTER_CWF_EN
                        r_start    <= cmd_wordOffset;
`else
                        // Without critical word first every line starts at word 0
                        r_start    <= cmd_wordOffset & '0;
`endif
                        r_issued   <= '0;
                        r_returned <= '0;
                        r_pending  <= '0;
                        r_state    <= cmd_write ? WB_FETCH : FILL;
                    end
                end
                FILL: begin
                    if (w_issue)  r_issued   <= r_issued + ONE_C;
                    if (w_return) r_returned <= r_returned + ONE_C;
                    if (w_issue && !w_return)      r_pending <= r_pending + ONE_C;
                    else if (!w_issue && w_return) r_pending <= r_pending - ONE_C;
                    if (w_return && (r_returned == LAST)) r_state <= DONE;
                end
                WB_FETCH: r_state <= WB_WRITE;
                WB_WRITE: begin
                    if (w_wb_adv) begin
                        if (w_last_wr) r_state  <= DONE;
                        else           r_issued <= r_issued + ONE_C;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_rw_master.sv
// tb/tb_cache_rw_master.sv - scoreboard bench for cache_rw_master with bus slave and data RAM models
module tb_cache_rw_master;
    logic        clk = 1'b0;
    logic        rest;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [25:0] cmd_lineAddr;
    logic [3:0]  cmd_wordOffset;
    logic        fill_valid;
    logic [3:0]  fill_index;
    logic [31:0] fill_data;
    logic        wb_read;
    logic [3:0]  wb_index;
    logic [31:0] wb_data;
    logic        done;
    logic [31:0] m0_address;
    logic [3:0]  m0_byteEnable;
    logic        m0_read;
    logic        m0_write;
    logic [31:0] m0_writeData;
    logic [31:0] m0_readData;
    logic        m0_waitRequest;
    logic        m0_readDataValid;

    always #5 clk = ~clk;

    cache_rw_master dut (
        .clk              (clk),
        .rest             (rest),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_write        (cmd_write),
        .cmd_lineAddr     (cmd_lineAddr),
        .cmd_wordOffset   (cmd_wordOffset),
        .fill_valid       (fill_valid),
        .fill_index       (fill_index),
        .fill_data        (fill_data),
        .wb_read          (wb_read),
        .wb_index         (wb_index),
        .wb_data          (wb_data),
        .done             (done),
        .m0_address       (m0_address),
        .m0_byteEnable    (m0_byteEnable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writeData     (m0_writeData),
        .m0_readData      (m0_readData),
        .m0_waitRequest   (m0_waitRequest),
        .m0_readDataValid (m0_readDataValid)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rd_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [31:0] exp_addr[$];
    logic [35:0] exp_fill[$];
    logic [63:0] exp_wr[$];
    rd_t         rd_q[$];

    logic        ev_issue   = 1'b0;
    logic [31:0] ev_issue_addr = '0;
    logic        ev_wb_read = 1'b0;
    logic [3:0]  ev_wb_idx  = '0;
    int          hold_until   = 0;
    int          stall_word   = 0;
    int          stall_left   = 0;
    int          inject_stale = 0;
    bit          expect_stale = 1'b0;
    bit          wr_stalled   = 1'b0;
    logic [31:0] held_addr = '0;
    logic [31:0] held_data = '0;
    int          issue_cnt = 0;
    int          ret_cnt   = 0;
    int          outstanding = 0;
    int          stall_cycles = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          acc_cyc  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    function automatic logic [31:0] ram_val(input logic [3:0] i);
        return 32'hC0DE0000 + 32'(i) * 32'h00000101;
    endfunction

    function automatic int start_of(input logic [3:0] off);
`ifdef CACHE_RW_MASTER_CWF_EN
        return int'(off);
`else
        return 0;
`endif
    endfunction

    // Bus slave and data RAM: drive inputs 1ns after each rising edge
    initial begin
        m0_waitRequest   = 1'b0;
        m0_readDataValid = 1'b0;
        m0_readData      = '0;
        wb_data          = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (ev_issue) rd_q.push_back('{ev_issue_addr, cyc + 1});
            m0_readDataValid = 1'b0;
            m0_readData      = 32'hBAD00000 ^ 32'(cyc);
            if (inject_stale > 0) begin
                inject_stale--;
                m0_readDataValid = 1'b1;
                m0_readData      = 32'h57A1E000;
            end else if (rd_q.size() > 0 && rd_q[0].due <= cyc && cyc >= hold_until) begin
                m0_readDataValid = 1'b1;
                m0_readData      = memf(rd_q[0].addr);
                void'(rd_q.pop_front());
            end
            wb_data = ev_wb_read ? ram_val(ev_wb_idx) : (32'hDEAD0000 ^ 32'(cyc));
            m0_waitRequest = 1'b0;
            if (m0_write && m0_address[5:2] == 4'(stall_word) && stall_left > 0) begin
                m0_waitRequest = 1'b1;
                stall_left--;
            end
        end
    end

    // Monitor: sample mid-cycle, score every handshake
    initial begin
        logic [31:0] ea;
        logic [35:0] ef;
        logic [63:0] ew;
        forever begin
            @(negedge clk);
            if (rest) begin
                ev_issue   = 1'b0;
                ev_wb_read = 1'b0;
            end else begin
                ev_issue      = m0_read && !m0_waitRequest;
                ev_issue_addr = m0_address;
                ev_wb_read    = wb_read;
                ev_wb_idx     = wb_index;
                if (m0_read || m0_write) check_eq("rw_overlap", m0_read & m0_write, 0);
                if (m0_read) check_eq("pending_max", outstanding < 4, 1);
                if (ev_issue) begin
                    issue_cnt++;
                    outstanding++;
                    check_eq("issue_expected", exp_addr.size() > 0, 1);
                    if (exp_addr.size() > 0) begin
                        ea = exp_addr.pop_front();
                        check_eq("issue_addr", m0_address, ea);
                    end
                end
                if (expect_stale && m0_readDataValid) check_eq("stale_ignored", fill_valid, 0);
                if (fill_valid) begin
                    ret_cnt++;
                    outstanding--;
                    check_eq("fill_expected", exp_fill.size() > 0, 1);
                    if (exp_fill.size() > 0) begin
                        ef = exp_fill.pop_front();
                        check_eq("fill_index", fill_index, ef[35:32]);
                        check_eq("fill_data", fill_data, ef[31:0]);
                    end
                end
                if (m0_write) begin
                    if (wr_stalled) begin
                        check_eq("wb_hold_addr", m0_address, held_addr);
                        check_eq("wb_hold_data", m0_writeData, held_data);
                    end
                    if (m0_waitRequest) begin
                        wr_stalled = 1'b1;
                        held_addr  = m0_address;
                        held_data  = m0_writeData;
                        stall_cycles++;
                    end else begin
                        wr_stalled = 1'b0;
                        check_eq("wb_expected", exp_wr.size() > 0, 1);
                        if (exp_wr.size() > 0) begin
                            ew = exp_wr.pop_front();
                            check_eq("wb_addr", m0_address, ew[63:32]);
                            check_eq("wb_data", m0_writeData, ew[31:0]);
                        end
                    end
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (cmd_valid && cmd_ready) acc_cyc = cyc;
            end
        end
    end

    // Called 1ns after a rising edge; pushes the whole line's expectations then waits for accept
    task automatic send_cmd(input logic w, input logic [25:0] line, input logic [3:0] off, input bit keep);
        int          s;
        int          n;
        logic [3:0]  wi;
        logic [31:0] a;
        s = start_of(off);
        for (int i = 0; i < 16; i++) begin
            wi = 4'(s + i);
            a  = {line, wi, 2'b00};
            if (w) exp_wr.push_back({a, ram_val(wi)});
            else begin
                exp_addr.push_back(a);
                exp_fill.push_back({wi, memf(a)});
            end
        end
        cmd_write      = w;
        cmd_lineAddr   = line;
        cmd_wordOffset = off;
        cmd_valid      = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        check_eq("cmd_accept", cmd_ready, 1);
        @(posedge clk);
        #1;
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int lim);
        int n;
        n = 0;
        while (done_cnt == d0 && n < lim) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("done_single", done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        int i0;
        int sc0;
        int f0;
        int n;
        rest           = 1'b1;
        cmd_valid      = 1'b0;
        cmd_write      = 1'b0;
        cmd_lineAddr   = '0;
        cmd_wordOffset = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_byte_en", m0_byteEnable, 4'hF);
        check_eq("rst_m0_read", m0_read, 0);
        check_eq("rst_m0_write", m0_write, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_fill_valid", fill_valid, 0);
        check_eq("rst_fill_data", fill_data, 0);
        check_eq("rst_wb_read", wb_read, 0);
        check_eq("rst_m0_address", m0_address, 0);
        check_eq("rst_m0_wdata", m0_writeData, 0);
        @(posedge clk);
        #1;
        rest = 1'b0;

        // Plain fill of line 0x40: addresses 0x1000..0x103C
        d0 = done_cnt;
        send_cmd(1'b0, 26'h40, 4'd0, 1'b0);
        wait_done(d0, 300);
        check_eq("fill1_q_empty", exp_fill.size() + exp_addr.size(), 0);

        // Fill with returns withheld: only MAX_PENDING reads go out
        d0 = done_cnt;
        i0 = issue_cnt;
        hold_until = cyc + 14;
        send_cmd(1'b0, 26'h1234, 4'd9, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check_eq("withheld_issues", issue_cnt - i0, 4);
        check_eq("withheld_read_low", m0_read, 0);
        @(posedge clk);
        #1;
        wait_done(d0, 300);
        check_eq("withheld_total", issue_cnt - i0, 16);
        hold_until = 0;

        // Writeback with a 3-cycle stall on word 5
        d0 = done_cnt;
        sc0 = stall_cycles;
        stall_word = 5;
        stall_left = 3;
        send_cmd(1'b1, 26'h41, 4'd0, 1'b0);
        wait_done(d0, 300);
        check_eq("wb_stall_cycles", stall_cycles - sc0, 3);
        check_eq("wb_q_empty", exp_wr.size(), 0);

        // Back-to-back writeback then fill
        d0 = done_cnt;
        send_cmd(1'b1, 26'h42, 4'd0, 1'b1);
        send_cmd(1'b0, 26'h43, 4'd0, 1'b0);
        check_eq("b2b_accept_gap", acc_cyc - done_cyc, 1);
        wait_done(d0 + 1, 300);
        check_eq("b2b_q_empty", exp_wr.size() + exp_fill.size() + exp_addr.size(), 0);

        // Reset mid-fill after 7 returns
        d0 = done_cnt;
        f0 = ret_cnt;
        send_cmd(1'b0, 26'h44, 4'd0, 1'b0);
        n = 0;
        while (ret_cnt - f0 < 7 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("midfill_returns", ret_cnt - f0 >= 7, 1);
        rest = 1'b1;
        @(posedge clk);
        #1;
        rest         = 1'b0;
        expect_stale = 1'b1;
        exp_addr.delete();
        exp_fill.delete();
        outstanding  = 0;
        @(negedge clk);
        check_eq("abort_cmd_ready", cmd_ready, 1);
        check_eq("abort_m0_read", m0_read, 0);
        inject_stale = 2;
        repeat (20) @(posedge clk);
        #1;
        check_eq("abort_no_done", done_cnt - d0, 0);
        expect_stale = 1'b0;

`ifdef CACHE_RW_MASTER_CWF_EN
        // Critical word first: words 13,14,15,0..12
        d0 = done_cnt;
        send_cmd(1'b0, 26'h45, 4'd13, 1'b0);
        wait_done(d0, 300);
        check_eq("cwf_q_empty", exp_fill.size() + exp_addr.size(), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end
endmodule
